// File: rtl/interval_timer_master_pkg.sv
// Shared definitions for the interval timer master: slave register map,
// control-word bit positions and the sequencer state encoding.
package interval_timer_master_pkg;

   // Timer slave word addresses
   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   // Control register bit positions
   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_PL,
      S_WR_PH,
      S_WR_CTRL,
      S_RUN,
      S_CLR_ST,
      S_STOP_CTRL,
      S_STOP_CLR,
      S_SNAP_W,
      S_SNAP_RL,
      S_SNAP_RH,
      S_SNAP_CAP
   } state_e;

   // Build a control-register write word from individual bits
   function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                             input logic start, input logic stop);
      logic [15:0] w;
      w             = '0;
      w[CTRL_ITO]   = ito;
      w[CTRL_CONT]  = cont;
      w[CTRL_START] = start;
      w[CTRL_STOP]  = stop;
      return w;
   endfunction

endpackage

// File: rtl/interval_timer_master_if.sv
// Avalon-MM link between the timer master and the interval timer slave,
// including the slave's level interrupt.
interface interval_timer_master_if;
   logic [2:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata;
   logic        timer_irq;

   modport master (
      output avm_address, avm_chipselect, avm_write_n, avm_writedata,
      input  avm_readdata, timer_irq
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
      output avm_readdata, timer_irq
   );
endinterface

// File: rtl/interval_timer_master.sv
// Interval timer master: programs the 16-bit interval timer slave, services
// its timeout interrupt (tick pulse + tick count) and captures counter
// snapshots on request. One FSM sequences all bus transfers.
module interval_timer_master
   import interval_timer_master_pkg::*;
#(
   parameter int TICK_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          cfg_period,
   input  logic                 cfg_continuous,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 snap_req,
   output logic                 busy,
   output logic                 running,
   output logic                 tick,
   output logic [TICK_W-1:0]    tick_count,
   output logic                 snap_valid,
   output logic [31:0]          snap_value,
   interval_timer_master_if.master avm
);

   state_e              state_q, state_d;
   logic                p_start_q, p_start_d;
   logic                p_stop_q,  p_stop_d;
   logic                p_snap_q,  p_snap_d;
   logic                cont_q,    cont_d;
   logic [TICK_W-1:0]   tcnt_q,    tcnt_d;
   logic [15:0]         snap_lo_q, snap_lo_d;
   logic [31:0]         snap_q,    snap_d;

   logic                clr_start, clr_stop, clr_snap;
   logic [2:0]          addr_c;
   logic                cs_c, wn_c;
   logic [15:0]         wd_c;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         p_start_q <= 1'b0;
         p_stop_q  <= 1'b0;
         p_snap_q  <= 1'b0;
         cont_q    <= 1'b0;
         tcnt_q    <= '0;
         snap_lo_q <= '0;
         snap_q    <= '0;
      end else begin
         state_q   <= state_d;
         p_start_q <= p_start_d;
         p_stop_q  <= p_stop_d;
         p_snap_q  <= p_snap_d;
         cont_q    <= cont_d;
         tcnt_q    <= tcnt_d;
         snap_lo_q <= snap_lo_d;
         snap_q    <= snap_d;
      end
   end

   // Next state, bus transfer decode and request consumption
   always_comb begin
      state_d    = state_q;
      clr_start  = 1'b0;
      clr_stop   = 1'b0;
      clr_snap   = 1'b0;
      addr_c     = 3'd0;
      cs_c       = 1'b0;
      wn_c       = 1'b1;
      wd_c       = 16'h0000;
      tick       = 1'b0;
      snap_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            // stop/snap have nothing to act on while the timer is idle
            clr_stop = 1'b1;
            clr_snap = 1'b1;
            if (p_start_q) begin
               clr_start = 1'b1;
               state_d   = S_WR_PL;
            end
         end
         S_WR_PL: begin
            cs_c = 1'b1; wn_c = 1'b0; addr_c = ADDR_PERIODL; wd_c = cfg_period[15:0];
            state_d = S_WR_PH;
         end
         S_WR_PH: begin
            cs_c = 1'b1; wn_c = 1'b0; addr_c = ADDR_PERIODH; wd_c = cfg_period[31:16];
            state_d = S_WR_CTRL;
         end
         S_WR_CTRL: begin
            cs_c = 1'b1; wn_c = 1'b0; addr_c = ADDR_CONTROL;
            wd_c = ctrl_word(1'b1, cfg_continuous, 1'b1, 1'b0);
            state_d = S_RUN;
         end
         S_RUN: begin
            if (avm.timer_irq) begin
               state_d = S_CLR_ST;
            end else if (p_stop_q) begin
               clr_stop = 1'b1;
               state_d  = S_STOP_CTRL;
            end else if (p_start_q) begin
               clr_start = 1'b1;
               state_d   = S_WR_PL;
            end else if (p_snap_q) begin
               clr_snap = 1'b1;
               state_d  = S_SNAP_W;
            end
         end
         S_CLR_ST: begin
            // clearing TO drops the irq before RUN looks at it again
            cs_c = 1'b1; wn_c = 1'b0; addr_c = ADDR_STATUS;
            tick    = 1'b1;
            state_d = cont_q ? S_RUN : S_IDLE;
         end
         S_STOP_CTRL: begin
            cs_c = 1'b1; wn_c = 1'b0; addr_c = ADDR_CONTROL;
            wd_c = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
            state_d = S_STOP_CLR;
         end
         S_STOP_CLR: begin
            cs_c = 1'b1; wn_c = 1'b0; addr_c = ADDR_STATUS;
            state_d = S_IDLE;
         end
         S_SNAP_W: begin
            cs_c = 1'b1; wn_c = 1'b0; addr_c = ADDR_SNAPL;
            state_d = S_SNAP_RL;
         end
         S_SNAP_RL: begin
            cs_c = 1'b1; addr_c = ADDR_SNAPL;
            state_d = S_SNAP_RH;
         end
         S_SNAP_RH: begin
            cs_c = 1'b1; addr_c = ADDR_SNAPH;
            state_d = S_SNAP_CAP;
         end
         S_SNAP_CAP: begin
            snap_valid = 1'b1;
            state_d    = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sticky request flags: a new pulse always wins over consumption
   always_comb begin
      p_start_d = start    | (p_start_q & ~clr_start);
      p_stop_d  = stop     | (p_stop_q  & ~clr_stop);
      p_snap_d  = snap_req | (p_snap_q  & ~clr_snap);
   end

   // Mode latch, tick counter and snapshot capture
   always_comb begin
      cont_d    = cont_q;
      tcnt_d    = tcnt_q;
      snap_lo_d = snap_lo_q;
      snap_d    = snap_q;
      if (state_q == S_WR_CTRL) begin
         cont_d = cfg_continuous;
         tcnt_d = '0;
      end
      if (state_q == S_CLR_ST)
         tcnt_d = tcnt_q + {{(TICK_W-1){1'b0}}, 1'b1};
      if (state_q == S_SNAP_RH)
         snap_lo_d = avm.avm_readdata;
      if (state_q == S_SNAP_CAP)
         snap_d = {avm.avm_readdata, snap_lo_q};
   end

   // The high half arrives during SNAP_CAP, so bypass it onto the output
   // to make snap_value valid in the same cycle as snap_valid.
   assign snap_value = (state_q == S_SNAP_CAP) ? {avm.avm_readdata, snap_lo_q} : snap_q;
   assign tick_count = tcnt_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_RUN);
   assign running    = (state_q == S_RUN) || (state_q == S_CLR_ST) ||
                       (state_q == S_SNAP_W) || (state_q == S_SNAP_RL) ||
                       (state_q == S_SNAP_RH) || (state_q == S_SNAP_CAP);

   assign avm.avm_address    = addr_c;
   assign avm.avm_chipselect = cs_c;
   assign avm.avm_write_n    = wn_c;
   assign avm.avm_writedata  = wd_c;

endmodule

// File: tb/tb_interval_timer_master.sv
// Directed bench for interval_timer_master with a behavioural model of the
// 16-bit interval timer slave (counter, TO status, snapshot, 1-cycle reads).
module tb_interval_timer_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cfg_period = '0;
   logic        cfg_continuous = 1'b0;
   logic        start = 1'b0, stop = 1'b0, snap_req = 1'b0;
   logic        busy, running, tick, snap_valid;
   logic [31:0] tick_count;
   logic [31:0] snap_value;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int st_wr_cnt = 0;

   interval_timer_master_if bus();

   interval_timer_master #(.TICK_W(32)) dut (
      .clk(clk), .reset(reset),
      .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
      .start(start), .stop(stop), .snap_req(snap_req),
      .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
      .snap_valid(snap_valid), .snap_value(snap_value),
      .avm(bus)
   );

   always #5 clk = ~clk;

   // ---------------- timer slave model ----------------
   logic [31:0] m_period, m_cnt, m_snap;
   logic        m_run, m_cont, m_ito, m_to;
   logic [15:0] m_rdata;
   logic        m_hold = 1'b0, m_force = 1'b0, m_force_to = 1'b0;
   logic [31:0] m_force_val = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_period <= '0; m_cnt <= '0; m_snap <= '0; m_run <= 1'b0;
         m_cont <= 1'b0; m_ito <= 1'b0; m_to <= 1'b0; m_rdata <= '0;
      end else begin
         if (m_force) m_cnt <= m_force_val;
         else if (m_run && !m_hold) begin
            if (m_cnt == 0) begin
               m_to  <= 1'b1;
               m_cnt <= m_period;
               if (!m_cont) m_run <= 1'b0;
            end else m_cnt <= m_cnt - 1;
         end
         if (m_force_to) m_to <= 1'b1;
         if (bus.avm_chipselect && !bus.avm_write_n) begin
            case (bus.avm_address)
               3'd0: m_to <= 1'b0;
               3'd1: begin
                  m_ito  <= bus.avm_writedata[0];
                  m_cont <= bus.avm_writedata[1];
                  if (bus.avm_writedata[2]) m_run <= 1'b1;
                  if (bus.avm_writedata[3]) m_run <= 1'b0;
               end
               3'd2: begin
                  m_period[15:0] <= bus.avm_writedata;
                  m_cnt <= {m_period[31:16], bus.avm_writedata};
                  m_run <= 1'b0;
               end
               3'd3: begin
                  m_period[31:16] <= bus.avm_writedata;
                  m_cnt <= {bus.avm_writedata, m_period[15:0]};
                  m_run <= 1'b0;
               end
               3'd4: m_snap <= m_cnt;
               default: ;
            endcase
         end
         if (bus.avm_chipselect && bus.avm_write_n)
            m_rdata <= (bus.avm_address == 3'd4) ? m_snap[15:0] :
                       (bus.avm_address == 3'd5) ? m_snap[31:16] : 16'h0000;
      end
   end

   assign bus.avm_readdata = m_rdata;
   assign bus.timer_irq    = m_to & m_ito;

   // cycle counter and status-write monitor
   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3'd0)
         st_wr_cnt <= st_wr_cnt + 1;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   function automatic logic [20:0] busv();
      return {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata};
   endfunction

   task automatic pulse_start(input logic [31:0] p, input logic c);
      cfg_period = p; cfg_continuous = c; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      checks++;
      if ({busy, running, tick, snap_valid} !== 4'b0000) begin
         failures++; $display("FAIL reset_flags got %b exp 0000", {busy, running, tick, snap_valid});
      end
      checks++;
      if (busv() !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
         failures++; $display("FAIL reset_bus got %h exp %h", busv(), {1'b0, 1'b1, 3'd0, 16'h0000});
      end
      checks++;
      if (tick_count !== 0 || snap_value !== 0) begin
         failures++; $display("FAIL reset_counts got %h/%h exp 0/0", tick_count, snap_value);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_write_seq();
      logic [20:0] exp_w [3];
      exp_w[0] = {1'b1, 1'b0, 3'd2, 16'h86A0};
      exp_w[1] = {1'b1, 1'b0, 3'd3, 16'h0001};
      exp_w[2] = {1'b1, 1'b0, 3'd1, 16'h0007};
      pulse_start(32'h0001_86A0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (busv() !== exp_w[i] || busy !== 1'b1) begin
            failures++; $display("FAIL write_seq[%0d] got %h busy=%b exp %h busy=1", i, busv(), busy, exp_w[i]);
         end
      end
      step();
      checks++;
      if (running !== 1'b1 || busy !== 1'b0 || busv() !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
         failures++; $display("FAIL write_run got run=%b busy=%b bus=%h exp run=1 busy=0 idle", running, busy, busv());
      end
   endtask

   task automatic test_tick_count();
      int t[5];
      int n = 0;
      int st0;
      st0 = st_wr_cnt;
      pulse_start(32'd9, 1'b1);
      for (int i = 0; i < 200 && n < 5; i++) begin
         step();
         if (tick === 1'b1) begin t[n] = cyc_n; n++; end
      end
      checks++;
      if (n != 5) begin
         failures++; $display("FAIL tick_timeout got %0d ticks exp 5", n);
      end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (n == 5 && t[i] - t[i-1] != 10) begin
            failures++; $display("FAIL tick_interval[%0d] got %0d exp 10", i, t[i] - t[i-1]);
         end
      end
      step();
      checks++;
      if (tick_count !== 32'd5) begin
         failures++; $display("FAIL tick_count got %0d exp 5", tick_count);
      end
      checks++;
      if (st_wr_cnt - st0 != 5) begin
         failures++; $display("FAIL status_writes got %0d exp 5", st_wr_cnt - st0);
      end
   endtask

   task automatic test_stop();
      int nt = 0;
      stop = 1'b1; step(); stop = 1'b0;
      step();
      checks++;
      if (busv() !== {1'b1, 1'b0, 3'd1, 16'h0008} || busy !== 1'b1 || running !== 1'b0) begin
         failures++; $display("FAIL stop_ctrl got %h busy=%b run=%b exp %h busy=1 run=0", busv(), busy, running, {1'b1, 1'b0, 3'd1, 16'h0008});
      end
      step();
      checks++;
      if (busv() !== {1'b1, 1'b0, 3'd0, 16'h0000} || tick !== 1'b0) begin
         failures++; $display("FAIL stop_clr got %h tick=%b exp %h tick=0", busv(), tick, {1'b1, 1'b0, 3'd0, 16'h0000});
      end
      step();
      checks++;
      if (busy !== 1'b0 || running !== 1'b0 || tick_count !== 32'd5) begin
         failures++; $display("FAIL stop_idle got busy=%b run=%b cnt=%0d exp 0/0/5", busy, running, tick_count);
      end
      for (int i = 0; i < 25; i++) begin step(); if (tick === 1'b1) nt++; end
      checks++;
      if (nt != 0) begin
         failures++; $display("FAIL stop_no_tick got %0d ticks exp 0", nt);
      end
   endtask

   task automatic test_one_shot();
      int nt = 0;
      pulse_start(32'd4, 1'b0);
      step(); step(); step();
      checks++;
      if (busv() !== {1'b1, 1'b0, 3'd1, 16'h0005}) begin
         failures++; $display("FAIL oneshot_ctrl got %h exp %h", busv(), {1'b1, 1'b0, 3'd1, 16'h0005});
      end
      for (int i = 0; i < 50 && nt == 0; i++) begin step(); if (tick === 1'b1) nt++; end
      checks++;
      if (nt != 1) begin
         failures++; $display("FAIL oneshot_timeout got %0d ticks exp 1", nt);
      end
      step();
      checks++;
      if (running !== 1'b0 || busy !== 1'b0 || tick_count !== 32'd1) begin
         failures++; $display("FAIL oneshot_idle got run=%b busy=%b cnt=%0d exp 0/0/1", running, busy, tick_count);
      end
      for (int i = 0; i < 20; i++) begin step(); if (tick === 1'b1) nt++; end
      checks++;
      if (nt != 1) begin
         failures++; $display("FAIL oneshot_single got %0d ticks exp 1", nt);
      end
   endtask

   task automatic test_snapshot();
      pulse_start(32'h0000_FFFF, 1'b1);
      step(); step(); step(); step();
      m_hold = 1'b1; m_force = 1'b1; m_force_val = 32'h0000_1234;
      step();
      m_force = 1'b0;
      snap_req = 1'b1; step(); snap_req = 1'b0;
      step();
      checks++;
      if (busv() !== {1'b1, 1'b0, 3'd4, 16'h0000} || running !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL snap_w got %h run=%b busy=%b exp %h run=1 busy=1", busv(), running, busy, {1'b1, 1'b0, 3'd4, 16'h0000});
      end
      step();
      checks++;
      if (busv() !== {1'b1, 1'b1, 3'd4, 16'h0000} || snap_valid !== 1'b0) begin
         failures++; $display("FAIL snap_rl got %h sv=%b exp %h sv=0", busv(), snap_valid, {1'b1, 1'b1, 3'd4, 16'h0000});
      end
      step();
      checks++;
      if (busv() !== {1'b1, 1'b1, 3'd5, 16'h0000}) begin
         failures++; $display("FAIL snap_rh got %h exp %h", busv(), {1'b1, 1'b1, 3'd5, 16'h0000});
      end
      step();
      checks++;
      if (snap_valid !== 1'b1 || snap_value !== 32'h0000_1234 || bus.avm_chipselect !== 1'b0) begin
         failures++; $display("FAIL snap_cap got sv=%b val=%h cs=%b exp sv=1 val=00001234 cs=0", snap_valid, snap_value, bus.avm_chipselect);
      end
      step();
      checks++;
      if (snap_valid !== 1'b0 || snap_value !== 32'h0000_1234 || busy !== 1'b0) begin
         failures++; $display("FAIL snap_hold got sv=%b val=%h busy=%b exp 0/00001234/0", snap_valid, snap_value, busy);
      end
   endtask

   task automatic test_irq_during_snap();
      int nt = 0;
      m_force = 1'b1; m_force_val = 32'h0002_5678;
      step();
      m_force = 1'b0;
      snap_req = 1'b1; step(); snap_req = 1'b0;
      step();
      step();
      m_force_to = 1'b1;
      step();
      m_force_to = 1'b0;
      checks++;
      if (busv() !== {1'b1, 1'b1, 3'd5, 16'h0000} || tick !== 1'b0) begin
         failures++; $display("FAIL irqsnap_rh got %h tick=%b exp %h tick=0", busv(), tick, {1'b1, 1'b1, 3'd5, 16'h0000});
      end
      step();
      checks++;
      if (snap_valid !== 1'b1 || snap_value !== 32'h0002_5678 || tick !== 1'b0) begin
         failures++; $display("FAIL irqsnap_cap got sv=%b val=%h tick=%b exp 1/00025678/0", snap_valid, snap_value, tick);
      end
      step();
      checks++;
      if (tick !== 1'b0 || busy !== 1'b0 || running !== 1'b1 || bus.avm_chipselect !== 1'b0) begin
         failures++; $display("FAIL irqsnap_run got tick=%b busy=%b run=%b cs=%b exp 0/0/1/0", tick, busy, running, bus.avm_chipselect);
      end
      step();
      checks++;
      if (tick !== 1'b1 || busv() !== {1'b1, 1'b0, 3'd0, 16'h0000}) begin
         failures++; $display("FAIL irqsnap_clr got tick=%b bus=%h exp tick=1 bus=%h", tick, busv(), {1'b1, 1'b0, 3'd0, 16'h0000});
      end
      for (int i = 0; i < 6; i++) begin step(); if (tick === 1'b1) nt++; end
      checks++;
      if (nt != 0 || tick_count !== 32'd1) begin
         failures++; $display("FAIL irqsnap_once got extra=%0d cnt=%0d exp 0/1", nt, tick_count);
      end
   endtask

   task automatic test_reset_mid();
      pulse_start(32'd100, 1'b1);
      step();
      step();
      checks++;
      if (busv() !== {1'b1, 1'b0, 3'd3, 16'h0000}) begin
         failures++; $display("FAIL rstmid_wrph got %h exp %h", busv(), {1'b1, 1'b0, 3'd3, 16'h0000});
      end
      reset = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || running !== 1'b0 || busv() !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
         failures++; $display("FAIL rstmid_idle got busy=%b run=%b bus=%h exp 0/0 idle", busy, running, busv());
      end
      checks++;
      if (tick_count !== 32'd0) begin
         failures++; $display("FAIL rstmid_count got %0d exp 0", tick_count);
      end
      reset = 1'b0;
      m_hold = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_write_seq();
      test_tick_count();
      test_stop();
      test_one_shot();
      test_snapshot();
      test_irq_during_snap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
